mode_sequencer: RTL and testbench
=================================

Name: mode_sequencer

Overview:
Central mode controller for the clock/alarm/stopwatch/game watch.
- Single-button mode cycling; produces registered one-hot enables for time_setting, alarm, stopwatch and mini_game.
- Pre-empts the active mode when the armed alarm matches and rings for a bounded time.
- Locks the mode while a game is running and generates commit pulses when setting modes are left.

Parameters:
RING_SECS, 30, alarm ring duration in 1 Hz ticks before auto-dismiss (1..255)
SNOOZE_SECS, 60, snooze delay in 1 Hz ticks (used only with SNOOZE_EN; 1..255)

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
tick_1hz  in  1  one-cycle pulse per second, synchronous to clk
mode_next  in  1  debounced single-cycle pulse: advance mode
ack  in  1  debounced single-cycle pulse: dismiss alarm
snooze  in  1  debounced single-cycle pulse: snooze (ignored without SNOOZE_EN)
alarm_armed  in  1  alarm enable switch level
alarm_match  in  1  level: current time equals alarm time
game_done  in  1  single-cycle pulse from mini_game
mode  out  3  encoded state (see Behaviour)
enable_time_set  out  1  one-hot enable
enable_alarm_set  out  1  one-hot enable
enable_stopwatch  out  1  one-hot enable
enable_game  out  1  one-hot enable
alarm_ringing  out  1  high in RING
commit_time  out  1  one-cycle pulse on leaving TIME_SET
commit_alarm  out  1  one-cycle pulse on leaving ALARM_SET

Behaviour:
- States and mode encoding: CLOCK=0, TIME_SET=1, ALARM_SET=2, STOPWATCH=3, GAME=4, RING=5, SNOOZE=6 (SNOOZE exists only with SNOOZE_EN).
- Reset (async assert, sync deassert handled upstream): state CLOCK, mode=0, all enables/alarm_ringing/commit pulses 0, ring counter 0, saved_mode CLOCK, alarm_pending 0, match_d 0.
- All outputs are registered. An output changes exactly 1 cycle after the causing input pulse.
- mode_next cycle: CLOCK->TIME_SET->ALARM_SET->STOPWATCH->GAME->CLOCK.
- Leaving TIME_SET via mode_next: commit_time=1 for one cycle. Leaving ALARM_SET: commit_alarm=1 for one cycle.
- GAME lock: mode_next is ignored in GAME. game_done returns to CLOCK. game_done outside GAME is ignored.
- Alarm event = rising edge of alarm_match (match_d registered), qualified by alarm_armed in the same cycle.
  - In CLOCK/STOPWATCH: go to RING, saved_mode=current state, ring counter=0. A simultaneous mode_next is dropped.
  - In TIME_SET/ALARM_SET: event is discarded (no pending).
  - In GAME: alarm_pending=1. On game_done with pending set: go to RING, saved_mode=CLOCK, pending cleared.
- RING: alarm_ringing=1, all enables 0. The counter increments on tick_1hz.
  - Exit to saved_mode on ack, or on the tick where the counter reaches RING_SECS. Both in the same cycle: single exit, same result.
  - mode_next is ignored in RING.
  - alarm_armed falling in RING: exit immediately to saved_mode.
- Counter width: $clog2(max(RING_SECS,SNOOZE_SECS)+1). It never wraps; it saturates at the limit.
- Reset mid-ring or mid-game: immediate return to reset state. No commit pulse.

Optional Feature:
SNOOZE_ALARM_EN
- Defined: snooze in RING goes to SNOOZE (alarm_ringing=0, saved_mode restored enables, counter=0). After SNOOZE_SECS ticks, return to RING with the counter cleared.
  - ack in SNOOZE cancels it.
  - mode_next in SNOOZE changes saved_mode per the normal cycle and leaves the timer running.
- Undefined: snooze port unused, SNOOZE state absent, mode value 6 never produced.

Decomposition:
- Shared package (tlc_pkg): mode encoding constants/typedef (CLOCK..SNOOZE), default RING_SECS/SNOOZE_SECS.
- One natural sub-module: sec_timer (tick-driven saturating counter with clear and done flag), used for both ring and snooze timing.
- FSM and output decode stay in mode_sequencer.

Test Plan:
- Reset low then high; 5 mode_next pulses -> mode 1,2,3,4 then held at 4. commit_time and commit_alarm each pulse once. enable_game=1.
- In GAME: game_done -> mode=0 next cycle, all enables 0.
- In STOPWATCH, alarm_armed=1, alarm_match rises with mode_next in the same cycle -> mode=5, alarm_ringing=1. After 30 ticks -> mode=3, enable_stopwatch=1.
- In GAME, alarm_match rises -> stays mode 4. Then game_done -> mode=5. ack -> mode 0.
- In ALARM_SET, alarm_match rises -> stays mode 2, no ring. Reset asserted in RING -> all outputs 0 asynchronously.
- With SNOOZE_ALARM_EN: RING + snooze -> mode 6. After 60 ticks -> mode 5. Then ack -> saved mode.

Source files
------------

// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared mode encoding and timing defaults for the watch mode sequencer
package tlc_pkg;

    typedef enum logic [2:0] {
        MODE_CLOCK     = 3'd0,
        MODE_TIME_SET  = 3'd1,
        MODE_ALARM_SET = 3'd2,
        MODE_STOPWATCH = 3'd3,
        MODE_GAME      = 3'd4,
        MODE_RING      = 3'd5,
        MODE_SNOOZE    = 3'd6
    } mode_t;

    localparam int DEFAULT_RING_SECS   = 30;
    localparam int DEFAULT_SNOOZE_SECS = 60;

    // Width needed to hold the larger of the two second limits.
    function automatic int timer_width(input int ring_secs, input int snooze_secs);
        int m;
        m = (ring_secs > snooze_secs) ? ring_secs : snooze_secs;
        return $clog2(m + 1);
    endfunction

    // Successor in the user-visible mode_next cycle; alarm states map to themselves.
    function automatic mode_t next_in_cycle(input mode_t m);
        case (m)
            MODE_CLOCK:     return MODE_TIME_SET;
            MODE_TIME_SET:  return MODE_ALARM_SET;
            MODE_ALARM_SET: return MODE_STOPWATCH;
            MODE_STOPWATCH: return MODE_GAME;
            MODE_GAME:      return MODE_CLOCK;
            default:        return m;
        endcase
    endfunction

endpackage

// File: rtl/sec_timer.sv
// rtl/sec_timer.sv - tick-driven saturating seconds counter with clear and done flag
module sec_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         run,
    input  logic         tick_1hz,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         done
);

    // done marks the tick that brings the count up to the limit, so the
    // caller can leave its state on exactly that second.
    assign done = run && tick_1hz && (count >= limit - W'(1));

    // Count seconds while running; clear wins over a coincident tick, and
    // the count parks at the limit instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && tick_1hz && (count < limit)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - watch mode FSM with alarm pre-emption, game lock and commit pulses (optional SNOOZE_ALARM_EN)
module mode_sequencer
    import tlc_pkg::*;
#(
    parameter int RING_SECS   = DEFAULT_RING_SECS,
    parameter int SNOOZE_SECS = DEFAULT_SNOOZE_SECS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       mode_next,
    input  logic       ack,
    input  logic       snooze,
    input  logic       alarm_armed,
    input  logic       alarm_match,
    input  logic       game_done,
    output logic [2:0] mode,
    output logic       enable_time_set,
    output logic       enable_alarm_set,
    output logic       enable_stopwatch,
    output logic       enable_game,
    output logic       alarm_ringing,
    output logic       commit_time,
    output logic       commit_alarm
);

    localparam int CW = timer_width(RING_SECS, SNOOZE_SECS);

    mode_t         state, next_state;
    mode_t         saved_mode, saved_next;
    mode_t         view_next;
    logic          pending, pending_next;
    logic          match_d;
    logic          alarm_event;
    logic          timer_clear, timer_run, timer_done;
    logic [CW-1:0] timer_limit;
    logic [CW-1:0] timer_count;
    logic          commit_time_next, commit_alarm_next;
    logic [3:0]    enables_next;

    assign alarm_event = alarm_armed && alarm_match && !match_d;
    assign timer_run   = (state == MODE_RING) || (state == MODE_SNOOZE);

`ifdef SNOOZE_ALARM_EN
    assign timer_limit = (state == MODE_SNOOZE) ? CW'(SNOOZE_SECS) : CW'(RING_SECS);
`else
    logic unused_snooze;
    assign unused_snooze = snooze;
    assign timer_limit   = CW'(RING_SECS);
`endif

    sec_timer #(.W(CW)) u_sec_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .run      (timer_run),
        .tick_1hz (tick_1hz),
        .limit    (timer_limit),
        .count    (timer_count),
        .done     (timer_done)
    );

    // Next-state, saved-mode bookkeeping and next values of the registered outputs.
    always_comb begin
        next_state        = state;
        saved_next        = saved_mode;
        pending_next      = pending;
        timer_clear       = 1'b0;
        commit_time_next  = 1'b0;
        commit_alarm_next = 1'b0;
        case (state)
            MODE_CLOCK: begin
                if (alarm_event) begin
                    next_state  = MODE_RING;
                    saved_next  = MODE_CLOCK;
                    timer_clear = 1'b1;
                end else if (mode_next) begin
                    next_state = MODE_TIME_SET;
                end
            end
            MODE_TIME_SET: begin
                if (mode_next) begin
                    next_state       = MODE_ALARM_SET;
                    commit_time_next = 1'b1;
                end
            end
            MODE_ALARM_SET: begin
                if (mode_next) begin
                    next_state        = MODE_STOPWATCH;
                    commit_alarm_next = 1'b1;
                end
            end
            MODE_STOPWATCH: begin
                if (alarm_event) begin
                    next_state  = MODE_RING;
                    saved_next  = MODE_STOPWATCH;
                    timer_clear = 1'b1;
                end else if (mode_next) begin
                    next_state = MODE_GAME;
                end
            end
            MODE_GAME: begin
                // An alarm during a game is deferred until the game ends.
                if (alarm_event) pending_next = 1'b1;
                if (game_done) begin
                    pending_next = 1'b0;
                    if (pending || alarm_event) begin
                        next_state  = MODE_RING;
                        saved_next  = MODE_CLOCK;
                        timer_clear = 1'b1;
                    end else begin
                        next_state = MODE_CLOCK;
                    end
                end
            end
            MODE_RING: begin
                if (!alarm_armed || ack || timer_done) begin
                    next_state = saved_mode;
                end
`ifdef SNOOZE_ALARM_EN
                else if (snooze) begin
                    next_state  = MODE_SNOOZE;
                    timer_clear = 1'b1;
                end
`endif
            end
`ifdef SNOOZE_ALARM_EN
            MODE_SNOOZE: begin
                if (ack) begin
                    next_state = saved_mode;
                end else begin
                    if (timer_done) begin
                        next_state  = MODE_RING;
                        timer_clear = 1'b1;
                    end
                    if (mode_next) saved_next = next_in_cycle(saved_mode);
                end
            end
`endif
            default: begin
                next_state = MODE_CLOCK;
            end
        endcase
    end

    // While snoozing the watch shows the mode it will return to.
    always_comb begin
        view_next    = (next_state == MODE_SNOOZE) ? saved_next : next_state;
        enables_next = 4'b0000;
        case (view_next)
            MODE_TIME_SET:  enables_next = 4'b1000;
            MODE_ALARM_SET: enables_next = 4'b0100;
            MODE_STOPWATCH: enables_next = 4'b0010;
            MODE_GAME:      enables_next = 4'b0001;
            default:        enables_next = 4'b0000;
        endcase
    end

    // State, bookkeeping and all outputs registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= MODE_CLOCK;
            saved_mode       <= MODE_CLOCK;
            pending          <= 1'b0;
            match_d          <= 1'b0;
            mode             <= 3'd0;
            enable_time_set  <= 1'b0;
            enable_alarm_set <= 1'b0;
            enable_stopwatch <= 1'b0;
            enable_game      <= 1'b0;
            alarm_ringing    <= 1'b0;
            commit_time      <= 1'b0;
            commit_alarm     <= 1'b0;
        end else begin
            state            <= next_state;
            saved_mode       <= saved_next;
            pending          <= pending_next;
            match_d          <= alarm_match;
            mode             <= next_state;
            enable_time_set  <= enables_next[3];
            enable_alarm_set <= enables_next[2];
            enable_stopwatch <= enables_next[1];
            enable_game      <= enables_next[0];
            alarm_ringing    <= (next_state == MODE_RING);
            commit_time      <= commit_time_next;
            commit_alarm     <= commit_alarm_next;
        end
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - scoreboard bench for mode_sequencer
module tb_mode_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0, mode_next = 1'b0, ack = 1'b0, snooze = 1'b0;
    logic       alarm_armed = 1'b0, alarm_match = 1'b0, game_done = 1'b0;
    logic [2:0] mode;
    logic       enable_time_set, enable_alarm_set, enable_stopwatch, enable_game;
    logic       alarm_ringing, commit_time, commit_alarm;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_v, got_v;

    always #5 clk = ~clk;

    mode_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .tick_1hz         (tick_1hz),
        .mode_next        (mode_next),
        .ack              (ack),
        .snooze           (snooze),
        .alarm_armed      (alarm_armed),
        .alarm_match      (alarm_match),
        .game_done        (game_done),
        .mode             (mode),
        .enable_time_set  (enable_time_set),
        .enable_alarm_set (enable_alarm_set),
        .enable_stopwatch (enable_stopwatch),
        .enable_game      (enable_game),
        .alarm_ringing    (alarm_ringing),
        .commit_time      (commit_time),
        .commit_alarm     (commit_alarm)
    );

    // Expected output vector {mode, enables[4], ringing, commit_time, commit_alarm}.
    function automatic logic [9:0] ev(input logic [2:0] m, input logic c_t, input logic c_a);
        logic [3:0] en;
        case (m)
            3'd1:    en = 4'b1000;
            3'd2:    en = 4'b0100;
            3'd3:    en = 4'b0010;
            3'd4:    en = 4'b0001;
            default: en = 4'b0000;
        endcase
        return {m, en, (m == 3'd5), c_t, c_a};
    endfunction

    function automatic logic [9:0] observed();
        return {mode, enable_time_set, enable_alarm_set, enable_stopwatch, enable_game,
                alarm_ringing, commit_time, commit_alarm};
    endfunction

    task automatic step(input logic mn, input logic tk, input logic ak, input logic gd, input logic sn);
        @(negedge clk);
        mode_next = mn; tick_1hz = tk; ack = ak; game_done = gd; snooze = sn;
        @(posedge clk);
        #1;
        mode_next = 1'b0; tick_1hz = 1'b0; ack = 1'b0; game_done = 1'b0; snooze = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got_v = observed();
        n_checks++;
        if (got_v !== 10'd0) begin
            n_errors++; $display("FAIL reset_state got=%h exp=%h", got_v, 10'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(ev(3'd0, 0, 0));
        step(0, 0, 0, 0, 0);
        exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL reset_release got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_mode_cycle();
        for (int i = 0; i < 6; i++) begin
            logic [2:0] m;
            m = (i < 4) ? 3'(i + 1) : 3'd4;
            exp_q.push_back(ev(m, (i == 1), (i == 2)));
            step((i < 5), 0, 0, 0, 0);
            exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL mode_cycle[%0d] got=%h exp=%h", i, got_v, exp_v); end
        end
    endtask

    task automatic test_game_done();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ev(3'd0, 0, 0));
            step(0, 0, 0, 1, 0);
            exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL game_done[%0d] got=%h exp=%h", i, got_v, exp_v); end
        end
    endtask

    task automatic test_ring_preempt();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ev(3'(i + 1), (i == 1), (i == 2)));
            step(1, 0, 0, 0, 0);
            exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL to_stopwatch[%0d] got=%h exp=%h", i, got_v, exp_v); end
        end
        alarm_armed = 1'b1;
        alarm_match = 1'b1;
        exp_q.push_back(ev(3'd5, 0, 0));
        step(1, 0, 0, 0, 0);
        exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL ring_enter got=%h exp=%h", got_v, exp_v); end
        for (int i = 1; i <= 30; i++) begin
            exp_q.push_back(ev((i < 30) ? 3'd5 : 3'd3, 0, 0));
            step(0, 1, 0, 0, 0);
            exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL ring_tick[%0d] got=%h exp=%h", i, got_v, exp_v); end
        end
        alarm_match = 1'b0;
        exp_q.push_back(ev(3'd3, 0, 0));
        step(0, 0, 0, 0, 0);
        exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL ring_done_hold got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_game_pending();
        logic [2:0] modes [5] = '{3'd4, 3'd4, 3'd5, 3'd5, 3'd0};
        logic [4:0] stim  [5] = '{5'b10000, 5'b00000, 5'b00010, 5'b10000, 5'b00100};
        for (int i = 0; i < 5; i++) begin
            if (i == 1) alarm_match = 1'b1;
            exp_q.push_back(ev(modes[i], 0, 0));
            step(stim[i][4], stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL game_pending[%0d] got=%h exp=%h", i, got_v, exp_v); end
        end
        alarm_match = 1'b0;
    endtask

    task automatic test_alarm_set_discard();
        logic [2:0] modes [7] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd0};
        logic       mn    [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            if (i == 2) alarm_match = 1'b1;
            if (i == 4) alarm_match = 1'b0;
            exp_q.push_back(ev(modes[i], (i == 1), (i == 3)));
            step(mn[i], 0, 0, (i == 6), 0);
            exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL discard[%0d] got=%h exp=%h", i, got_v, exp_v); end
        end
    endtask

    task automatic test_armed_drop();
        alarm_match = 1'b1;
        exp_q.push_back(ev(3'd5, 0, 0));
        step(0, 0, 0, 0, 0);
        exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL clock_ring got=%h exp=%h", got_v, exp_v); end
        alarm_armed = 1'b0;
        exp_q.push_back(ev(3'd0, 0, 0));
        step(0, 0, 0, 0, 0);
        exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL armed_drop got=%h exp=%h", got_v, exp_v); end
        alarm_armed = 1'b1;
        alarm_match = 1'b0;
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_in_ring();
        alarm_match = 1'b1;
        exp_q.push_back(ev(3'd5, 0, 0));
        step(0, 0, 0, 0, 0);
        exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL ring_before_reset got=%h exp=%h", got_v, exp_v); end
        #2;
        reset = 1'b0;
        alarm_match = 1'b0;
        #1;
        got_v = observed(); n_checks++;
        if (got_v !== 10'd0) begin n_errors++; $display("FAIL async_reset got=%h exp=%h", got_v, 10'd0); end
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(ev(3'd0, 0, 0));
        step(0, 0, 0, 0, 0);
        exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL after_reset got=%h exp=%h", got_v, exp_v); end
    endtask

`ifdef SNOOZE_ALARM_EN
    task automatic test_snooze();
        alarm_match = 1'b1;
        exp_q.push_back(ev(3'd5, 0, 0));
        step(0, 0, 0, 0, 0);
        exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL snooze_ring got=%h exp=%h", got_v, exp_v); end
        exp_q.push_back(ev(3'd6, 0, 0));
        step(0, 0, 0, 0, 1);
        exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL snooze_enter got=%h exp=%h", got_v, exp_v); end
        for (int i = 1; i <= 60; i++) begin
            exp_q.push_back(ev((i < 60) ? 3'd6 : 3'd5, 0, 0));
            step(0, 1, 0, 0, 0);
            exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL snooze_tick[%0d] got=%h exp=%h", i, got_v, exp_v); end
        end
        exp_q.push_back(ev(3'd0, 0, 0));
        step(0, 0, 1, 0, 0);
        exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
        if (got_v !== exp_v) begin n_errors++; $display("FAIL snooze_ack got=%h exp=%h", got_v, exp_v); end
        alarm_match = 1'b0;
    endtask
`else
    task automatic test_snooze();
        alarm_match = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ev((i < 2) ? 3'd5 : 3'd0, 0, 0));
            step(0, 0, (i == 2), 0, (i == 1));
            exp_v = exp_q.pop_front(); got_v = observed(); n_checks++;
            if (got_v !== exp_v) begin n_errors++; $display("FAIL snooze_ignored[%0d] got=%h exp=%h", i, got_v, exp_v); end
        end
        alarm_match = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_mode_cycle();
        test_game_done();
        test_ring_preempt();
        test_game_pending();
        test_alarm_set_discard();
        test_armed_drop();
        test_reset_in_ring();
        test_snooze();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
